// File: rtl/execute_stage_md.sv
// execute_stage_md: MIPS execute stage with E/W forwarding, ALU, multi-cycle mult/div unit with HI/LO, and E->M register
module execute_stage_md #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int ALUOP_W     = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_AW-1:0]  rs_d,
  input  logic [REG_AW-1:0]  rt_d,
  input  logic [REG_AW-1:0]  rd_d,
  input  logic [DATA_W-1:0]  rd1_d,
  input  logic [DATA_W-1:0]  rd2_d,
  input  logic [DATA_W-1:0]  imm_d,
  input  logic [DATA_W-1:0]  pc_d,
  input  logic               reg_write_d,
  input  logic               mem_write_d,
  input  logic [1:0]         sd_to_reg_d,
  input  logic [ALUOP_W-1:0] alu_op_d,
  input  logic               alu_src_d,
  input  logic [1:0]         reg_dst_d,
  input  logic [2:0]         md_op_d,
  input  logic [1:0]         res_sel_d,
  input  logic               flush_e,
  input  logic [DATA_W-1:0]  result_w,
  input  logic [REG_AW-1:0]  write_reg_w,
  input  logic               reg_write_w,
  output logic               reg_write_e,
  output logic               mem_write_e,
  output logic [1:0]         sd_to_reg_e,
  output logic [DATA_W-1:0]  alu_out_e,
  output logic [DATA_W-1:0]  write_data_e,
  output logic [DATA_W-1:0]  pc_e,
  output logic [REG_AW-1:0]  write_reg_e,
  output logic [REG_AW-1:0]  write_reg_d,
  output logic               md_busy,
  output logic               md_drop
);
  localparam int SHW  = $clog2(DATA_W);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [DATA_W-1:0]   fwdE, srcA, fwdB, srcB, aluRes, resE;
  logic [DATA_W-1:0]   hi, lo, mdA, mdB, quotS, remS, quotU, remU;
  logic [2*DATA_W-1:0] prodS, prodU;
  logic [SHW-1:0]      shamt;
  logic [CW-1:0]       cnt;
  logic [2:0]          mdOp;
  logic                mdIdle, isMulDiv, isMd, mdStart;

  // a load sitting in E->M must not forward; the hazard unit stalls that case
  assign fwdE = (sd_to_reg_e == 2'd2) ? pc_e + DATA_W'(8) : alu_out_e;
  assign srcA = (reg_write_e && write_reg_e == rs_d && rs_d != '0 && sd_to_reg_e != 2'd1) ? fwdE :
                (reg_write_w && write_reg_w == rs_d && rs_d != '0) ? result_w : rd1_d;
  assign fwdB = (reg_write_e && write_reg_e == rt_d && rt_d != '0 && sd_to_reg_e != 2'd1) ? fwdE :
                (reg_write_w && write_reg_w == rt_d && rt_d != '0) ? result_w : rd2_d;
  assign srcB = alu_src_d ? imm_d : fwdB;
  assign shamt = srcA[SHW-1:0];

  assign write_reg_d = (reg_dst_d == 2'd0) ? rt_d :
                       (reg_dst_d == 2'd1) ? rd_d :
                       (reg_dst_d == 2'd2) ? '1 : '0;

  always_comb begin
    aluRes = '0;
    case (alu_op_d)
      ALUOP_W'(0):  aluRes = srcA + srcB;
      ALUOP_W'(1):  aluRes = srcA - srcB;
      ALUOP_W'(2):  aluRes = srcA | srcB;
      ALUOP_W'(3):  aluRes = srcA & srcB;
      ALUOP_W'(4):  aluRes = srcA ^ srcB;
      ALUOP_W'(5):  aluRes = ~(srcA | srcB);
      ALUOP_W'(6):  aluRes = DATA_W'($signed(srcA) < $signed(srcB));
      ALUOP_W'(7):  aluRes = DATA_W'(srcA < srcB);
      ALUOP_W'(8):  aluRes = srcB << (DATA_W / 2);
      ALUOP_W'(9):  aluRes = srcB << shamt;
      ALUOP_W'(10): aluRes = srcB >> shamt;
      ALUOP_W'(11): aluRes = $unsigned($signed(srcB) >>> shamt);
      default:      aluRes = '0;
    endcase
  end

  assign resE = (res_sel_d == 2'd1) ? hi : (res_sel_d == 2'd2) ? lo : aluRes;

  assign mdIdle   = (cnt == '0);
  assign isMulDiv = (md_op_d >= 3'd1) && (md_op_d <= 3'd4);
  assign isMd     = (md_op_d >= 3'd1) && (md_op_d <= 3'd6);
  assign mdStart  = isMulDiv && !flush_e && mdIdle;
  assign md_busy  = !mdIdle || (isMulDiv && !flush_e);

  assign prodS = $signed({{DATA_W{mdA[DATA_W-1]}}, mdA}) * $signed({{DATA_W{mdB[DATA_W-1]}}, mdB});
  assign prodU = {{DATA_W{1'b0}}, mdA} * {{DATA_W{1'b0}}, mdB};
  assign quotS = $signed(mdA) / $signed(mdB);
  assign remS  = $signed(mdA) % $signed(mdB);
  assign quotU = mdA / mdB;
  assign remU  = mdA % mdB;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mdA     <= '0;
      mdB     <= '0;
      mdOp    <= '0;
      md_drop <= 1'b0;
    end else begin
      md_drop <= isMd && !mdIdle && !flush_e;
      if (mdStart) begin
        mdA  <= srcA;
        mdB  <= fwdB;
        mdOp <= md_op_d;
        cnt  <= (md_op_d <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (!mdIdle) begin
        cnt <= cnt - CW'(1);
      end
      // results land on the last counting edge; a zero divisor leaves HI/LO untouched
      if (cnt == CW'(1)) begin
        if (mdOp == 3'd1) {hi, lo} <= prodS;
        else if (mdOp == 3'd2) {hi, lo} <= prodU;
        else if (mdB != '0) begin
          lo <= (mdOp == 3'd3) ? quotS : quotU;
          hi <= (mdOp == 3'd3) ? remS : remU;
        end
      end else if (mdIdle && !flush_e) begin
        if (md_op_d == 3'd5) hi <= srcA;
        if (md_op_d == 3'd6) lo <= srcA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      sd_to_reg_e  <= '0;
      alu_out_e    <= '0;
      write_data_e <= '0;
      pc_e         <= '0;
      write_reg_e  <= '0;
    end else begin
      reg_write_e  <= reg_write_d;
      mem_write_e  <= mem_write_d;
      sd_to_reg_e  <= sd_to_reg_d;
      alu_out_e    <= resE;
      write_data_e <= fwdB;
      pc_e         <= pc_d;
      write_reg_e  <= write_reg_d;
    end
  end
endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: scoreboard bench for execute_stage_md against an arithmetic reference model
module tb_execute_stage_md;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_d, rt_d, rd_d, write_reg_w, write_reg_e, write_reg_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d, result_w, alu_out_e, write_data_e, pc_e;
  logic reg_write_d, mem_write_d, alu_src_d, flush_e, reg_write_w;
  logic reg_write_e, mem_write_e, md_busy, md_drop;
  logic [1:0] sd_to_reg_d, reg_dst_d, res_sel_d, sd_to_reg_e;
  logic [3:0] alu_op_d;
  logic [2:0] md_op_d;

  always #5 clk = ~clk;

  execute_stage_md dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .sd_to_reg_d(sd_to_reg_d),
    .alu_op_d(alu_op_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
    .md_op_d(md_op_d), .res_sel_d(res_sel_d), .flush_e(flush_e),
    .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .sd_to_reg_e(sd_to_reg_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .pc_e(pc_e),
    .write_reg_e(write_reg_e), .write_reg_d(write_reg_d),
    .md_busy(md_busy), .md_drop(md_drop)
  );

  typedef struct packed {
    logic rw; logic mw; logic [1:0] sd; logic [4:0] wr;
    logic [31:0] alu; logic [31:0] wd; logic [31:0] pc; logic drop;
  } em_t;

  em_t q[$];
  em_t ex = '0;
  logic [31:0] hi = 0, lo = 0, pendHi = 0, pendLo = 0;
  int mdLeft = 0;
  bit pend = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] fe;
    fe = (ex.sd == 2'd2) ? ex.pc + 32'd8 : ex.alu;
    if (ex.rw && ex.wr == r && r != 0 && ex.sd != 2'd1) return fe;
    if (reg_write_w && write_reg_w == r && r != 0) return result_w;
    return v;
  endfunction

  function automatic logic [31:0] aluf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return {b[15:0], 16'h0};
      4'd9: return b << a[4:0];
      4'd10: return b >> a[4:0];
      4'd11: return $signed(b) >>> a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] wrd();
    return (reg_dst_d == 2'd0) ? rt_d : (reg_dst_d == 2'd1) ? rd_d : (reg_dst_d == 2'd2) ? 5'd31 : 5'd0;
  endfunction

  task automatic nop();
    reset = 0; rs_d = 0; rt_d = 0; rd_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0; pc_d = 0;
    reg_write_d = 0; mem_write_d = 0; sd_to_reg_d = 0; alu_op_d = 0; alu_src_d = 0;
    reg_dst_d = 0; md_op_d = 0; res_sel_d = 0; flush_e = 0;
    result_w = 0; write_reg_w = 0; reg_write_w = 0;
  endtask

  // one clock of stimulus: predict this edge, push the expectation, advance the model
  task automatic cyc();
    logic [31:0] a, b;
    em_t e;
    bit busy;
    longint p;
    longint unsigned pu;
    int sa, sb;
    #1;
    a = fwd(rs_d, rd1_d);
    b = fwd(rt_d, rd2_d);
    busy = (mdLeft != 0) || (md_op_d inside {[3'd1:3'd4]} && !flush_e);
    if (!reset) chk("md_busy", md_busy, busy);
    chk("write_reg_d", write_reg_d, wrd());
    e = '0;
    if (!reset && !flush_e) begin
      e.rw = reg_write_d; e.mw = mem_write_d; e.sd = sd_to_reg_d; e.wr = wrd();
      e.alu = (res_sel_d == 2'd1) ? hi : (res_sel_d == 2'd2) ? lo : aluf(alu_op_d, a, alu_src_d ? imm_d : b);
      e.wd = b; e.pc = pc_d;
    end
    e.drop = !reset && (md_op_d inside {[3'd1:3'd6]}) && mdLeft != 0 && !flush_e;
    q.push_back(e);
    if (reset) begin
      hi = 0; lo = 0; mdLeft = 0; pend = 0;
    end else if (mdLeft != 0) begin
      mdLeft--;
      if (mdLeft == 0 && pend) begin hi = pendHi; lo = pendLo; end
    end else if (!flush_e) begin
      sa = a; sb = b;
      case (md_op_d)
        3'd1: begin p = longint'(sa) * longint'(sb); {pendHi, pendLo} = p; pend = 1; mdLeft = 5; end
        3'd2: begin pu = longint'({32'h0, a}) * longint'({32'h0, b}); {pendHi, pendLo} = pu; pend = 1; mdLeft = 5; end
        3'd3: begin pend = (b != 0); if (pend) begin pendLo = sa / sb; pendHi = sa % sb; end mdLeft = 10; end
        3'd4: begin pend = (b != 0); if (pend) begin pendLo = a / b; pendHi = a % b; end mdLeft = 10; end
        3'd5: hi = a;
        3'd6: lo = a;
        default: ;
      endcase
    end
    ex = e;
    @(negedge clk);
  endtask

  task automatic readmd(input logic [1:0] sel, input string name, input logic [31:0] exp);
    nop(); res_sel_d = sel; cyc();
    chk(name, alu_out_e, exp);
  endtask

  task automatic mdrun(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    nop(); rs_d = 1; rt_d = 2; rd1_d = a; rd2_d = b; md_op_d = op; cyc();
    repeat (n) begin nop(); cyc(); end
  endtask

  initial begin
    em_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("em_ctrl", {reg_write_e, mem_write_e, sd_to_reg_e, write_reg_e}, {e.rw, e.mw, e.sd, e.wr});
        chk("alu_out_e", alu_out_e, e.alu);
        chk("write_data_e", write_data_e, e.wd);
        chk("pc_e", pc_e, e.pc);
        chk("md_drop", md_drop, e.drop);
      end
    end
  end

  initial begin
    nop(); reset = 1; cyc(); cyc();
    chk("rst_regs", {reg_write_e, sd_to_reg_e, write_reg_e, alu_out_e, pc_e}, 0);
    chk("rst_drop", md_drop, 0);
    // forwarding priority
    nop(); reg_write_d = 1; reg_dst_d = 1; rd_d = 5; rd1_d = 32'h11; alu_src_d = 1; cyc();
    nop(); rs_d = 5; rd1_d = 32'h99; reg_write_w = 1; write_reg_w = 5; result_w = 32'h22; alu_src_d = 1; cyc();
    chk("fwd_e_prio", alu_out_e, 32'h11);
    nop(); rd1_d = 32'h99; reg_write_w = 1; result_w = 32'h22; alu_src_d = 1; cyc();
    chk("fwd_r0", alu_out_e, 32'h99);
    nop(); rs_d = 5; rd1_d = 32'h99; reg_write_w = 1; write_reg_w = 5; result_w = 32'h22; alu_src_d = 1; cyc();
    chk("fwd_w", alu_out_e, 32'h22);
    // link forward
    nop(); pc_d = 32'h3000; sd_to_reg_d = 2; reg_dst_d = 2; reg_write_d = 1; cyc();
    chk("jal_wr", write_reg_e, 31);
    nop(); rs_d = 31; alu_src_d = 1; imm_d = 4; cyc();
    chk("link_fwd", alu_out_e, 32'h300C);
    // mult -3 x 7
    nop(); rs_d = 1; rt_d = 2; rd1_d = 32'hFFFFFFFD; rd2_d = 7; md_op_d = 1;
    #1 chk("mult_busy_start", md_busy, 1);
    cyc();
    for (int i = 0; i < 5; i++) begin nop(); #1 chk("mult_busy", md_busy, 1); cyc(); end
    nop(); #1 chk("mult_idle", md_busy, 0);
    readmd(2, "mult_lo", 32'hFFFFFFEB);
    readmd(1, "mult_hi", 32'hFFFFFFFF);
    // div -7/2, then divu by zero
    mdrun(3, 32'hFFFFFFF9, 2, 10);
    readmd(2, "div_lo", 32'hFFFFFFFD);
    readmd(1, "div_hi", 32'hFFFFFFFF);
    mdrun(4, 5, 0, 10);
    readmd(2, "div0_lo", 32'hFFFFFFFD);
    readmd(1, "div0_hi", 32'hFFFFFFFF);
    // drop: mthi during multu
    mdrun(2, 32'h10000, 32'h30000, 1);
    nop(); rs_d = 1; rd1_d = 32'hAAAA; md_op_d = 5; cyc();
    chk("drop_pulse", md_drop, 1);
    nop(); cyc();
    chk("drop_clear", md_drop, 0);
    repeat (3) begin nop(); cyc(); end
    readmd(1, "drop_hi", 32'h3);
    readmd(2, "drop_lo", 32'h0);
    nop(); rs_d = 1; rd1_d = 32'h1234; md_op_d = 5; cyc();
    readmd(1, "mthi", 32'h1234);
    // reset mid-div
    mdrun(3, 100, 7, 3);
    nop(); reset = 1; cyc();
    chk("rst_mid_out", {reg_write_e, alu_out_e, pc_e, write_reg_e}, 0);
    nop(); #1 chk("rst_mid_busy", md_busy, 0);
    repeat (10) begin nop(); cyc(); end
    readmd(2, "rst_mid_lo", 0);
    readmd(1, "rst_mid_hi", 0);
    // flush with mult in D
    nop(); md_op_d = 1; rd1_d = 3; rd2_d = 4; flush_e = 1; reg_write_d = 1; reg_dst_d = 1; rd_d = 9; pc_d = 32'h40;
    #1 chk("flush_no_busy", md_busy, 0);
    cyc();
    chk("flush_bubble", {reg_write_e, pc_e, write_reg_e}, 0);
    nop(); #1 chk("flush_no_start", md_busy, 0);
    cyc();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      rs_d = 5'($urandom_range(7)); rt_d = 5'($urandom_range(7)); rd_d = 5'($urandom_range(7));
      rd1_d = $urandom; rd2_d = $urandom;
      imm_d = ($urandom_range(2) == 0) ? $urandom : 32'($urandom_range(40));
      pc_d = $urandom & 32'hFFFFFFFC;
      reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
      sd_to_reg_d = 2'($urandom); alu_op_d = 4'($urandom); alu_src_d = 1'($urandom);
      reg_dst_d = 2'($urandom); res_sel_d = 2'($urandom);
      md_op_d = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
      flush_e = ($urandom_range(9) == 0);
      result_w = $urandom; write_reg_w = 5'($urandom_range(7)); reg_write_w = 1'($urandom);
      if (md_op_d inside {[3'd1:3'd4]} && fwd(rs_d, rd1_d) == 32'h80000000 && fwd(rt_d, rd2_d) == 32'hFFFFFFFF)
        md_op_d = 0;
      cyc();
    end
    nop();
    @(posedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised Execute stage for the pipelined MIPS core; successor to the fixed 32-bit E stage.
- Takes decoded D-stage operands and controls, resolves E/W forwarding (including link PC+8), runs the ALU, and registers results into the E→M pipeline register.
- Adds an iterative multiply/divide unit with HI/LO registers and a busy signal for the hazard unit.
- Adds a mfhi/mflo result path.

Parameters:
- DATA_W, 32, datapath width (even, ≥8).
- REG_AW, 5, register address width.
- ALUOP_W, 4, ALU opcode width.
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs_d, rt_d, rd_d  in  REG_AW each  source/dest register numbers.
- rd1_d, rd2_d  in  DATA_W  GRF read data.
- imm_d  in  DATA_W  extended immediate.
- pc_d  in  DATA_W  instruction PC.
- reg_write_d  in  1  register write enable.
- mem_write_d  in  1  memory write enable.
- sd_to_reg_d  in  2  write-back source: 0 ALU, 1 mem, 2 PC+8.
- alu_op_d  in  ALUOP_W  ALU operation.
- alu_src_d  in  1  B operand select: 0 forwarded rt, 1 imm.
- reg_dst_d  in  2  write register select: 0 rt, 1 rd, 2 all-ones.
- md_op_d  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- res_sel_d  in  2  E result select: 0 ALU, 1 HI, 2 LO.
- flush_e  in  1  load a bubble into the E→M register.
- result_w  in  DATA_W  W-stage write-back value.
- write_reg_w  in  REG_AW  W-stage destination register.
- reg_write_w  in  1  W-stage write enable.
- reg_write_e, mem_write_e  out  1  registered controls.
- sd_to_reg_e  out  2  registered control.
- alu_out_e, write_data_e, pc_e  out  DATA_W  registered data.
- write_reg_e  out  REG_AW  registered destination register.
- write_reg_d  out  REG_AW  combinational destination register, for the hazard unit.
- md_busy  out  1  combinational MD busy indication.
- md_drop  out  1  registered one-cycle pulse.

Behaviour:
- Reset: every registered output is 0, HI = LO = 0, MD counter = 0, and md_drop = 0. Reset mid-operation aborts the operation and leaves HI/LO at 0.
- Forward value of the E→M register: pc_e+8 if sd_to_reg_e==2, else alu_out_e.
- Forwarding, operand A (operand B identical using rt_d):
  - Use the E→M register value if reg_write_e, write_reg_e==rs_d, rs_d!=0 and sd_to_reg_e!=1.
  - Else use result_w if reg_write_w, write_reg_w==rs_d and rs_d!=0.
  - Else use rd1_d.
  - A load match in E→M falls through; the hazard unit guarantees a stall in that case.
- SrcB = alu_src_d ? imm_d : forwarded B. write_data_e always receives forwarded B.
- write_reg_d: reg 0 with reg_dst_d=3 selects 0.
- ALU ops (mod 2^DATA_W, no overflow trap):
  - 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 nor.
  - 6 slt (signed), 7 sltu.
  - 8 lui: B<<(DATA_W/2).
  - 9 sll: B<<A[log2 DATA_W-1:0], 10 srl, 11 sra.
  - Others produce 0.
- E result = ALU / HI / LO per res_sel_d. HI/LO are read as currently held; the hazard unit stalls mfhi/mflo while md_busy.
- E→M register on each edge: loads all D-derived values; if flush_e, controls and data load 0.
- MD unit:
  - Start when md_op_d∈{1..4}, !flush_e and counter==0. The edge captures the operands and loads the counter with MULT_CYCLES or DIV_CYCLES.
  - The counter decrements each edge. On the edge where the counter is 1, {HI,LO} is written: product (2·DATA_W) for mult, LO=quotient and HI=remainder for div.
  - div rounds toward zero; the remainder takes the dividend's sign.
  - Divisor 0: HI/LO unchanged, full DIV_CYCLES still elapse.
  - mthi/mtlo with counter==0 and !flush_e write HI/LO with forwarded A on the same edge.
- md_busy = (counter!=0) | (md_op_d∈{1..4} & !flush_e). It is therefore high from the start cycle through the final counting cycle.
- An MD op (1..6) arriving while counter!=0 and !flush_e is dropped: no HI/LO or counter change, and md_drop pulses on the next cycle.
- MD ops and flush_e are independent of ALU ops; an MD op still writes its E→M register slot with reg_write as decoded.

Test Plan:
- Forward priority: E→M holds r5=0x11 (ALU), W holds r5=0x22, rs_d=5 → SrcA=0x11. Repeat with rs_d=0 → rd1_d is used.
- Link forward: jal at pc 0x3000 in E→M (sd_to_reg_e=2, write_reg_e=31), next instruction uses rs=31 with add → alu_out_e=0x3008+B.
- mult: -3 × 7 (0xFFFFFFFD, 7), default params → md_busy high for 5 cycles after the start edge; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mflo → alu_out_e=0xFFFFFFEB.
- div: -7 / 2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 5/0 → HI/LO unchanged after 10 cycles.
- Drop: mthi issued 2 cycles into a mult → md_drop=1 for one cycle; HI equals the product high half.
- Reset: assert reset 3 cycles into a div → next cycle md_busy=0 (given md_op_d=0), HI=LO=0, all outputs 0. flush_e with a mult in D → no start, bubble loaded.
